// File: rtl/adc_slot_responder_if.sv
// Scan bus seen by one slot responder: readout drives addr/clr, responders
// return their share of the wired-OR data word.
interface adc_slot_responder_if;
    logic [7:0]  addr;
    logic [15:0] data;
    logic        clr;

    modport master (output addr, output clr, input data);
    modport slave  (input addr, input clr, output data);
endinterface

// File: rtl/adc_slot_responder.sv
// Single-hit ADC slot responder: trigger edge -> conversion delay -> threshold -> hold until read+cleared.
// Optional lost-trigger counter enabled by defining ADC_SLOT_LOST_CNT_EN.
module adc_slot_responder #(
    parameter int          CONV_CYCLES = 4,
    parameter logic [15:0] THRESH      = 16'd1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            slot,
    adc_slot_responder_if.slave   bus,
    input  logic                  trig,
    input  logic [15:0]           adc_in,
    output logic                  valid,
    output logic [7:0]            lost
);

    localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [15:0]        held_reg, held_next;
    logic               valid_reg, valid_next;
    logic               rd_flag_reg, rd_flag_next;
    logic               trig_d_reg;
    logic               trig_edge;
    logic               addr_hit;

    assign trig_edge = trig & ~trig_d_reg;
    assign addr_hit  = (bus.addr == slot);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            held_reg    <= 16'd0;
            valid_reg   <= 1'b0;
            rd_flag_reg <= 1'b0;
            trig_d_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            held_reg    <= held_next;
            valid_reg   <= valid_next;
            rd_flag_reg <= rd_flag_next;
            trig_d_reg  <= trig;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        held_next    = held_reg;
        valid_next   = valid_reg;
        rd_flag_next = rd_flag_reg;
        case (state_reg)
            IDLE: begin
                if (trig_edge) begin
                    state_next = CONV;
                    cnt_next   = CNT_W'(CONV_CYCLES - 1);
                end
            end
            CONV: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end else if (adc_in >= THRESH) begin
                    held_next    = adc_in;
                    valid_next   = 1'b1;
                    rd_flag_next = 1'b0;
                    state_next   = HOLD;
                end else begin
                    state_next = IDLE;
                end
            end
            HOLD: begin
                // A read on the same clock as clr still counts for this scan.
                if (bus.clr && (rd_flag_reg || addr_hit)) begin
                    valid_next   = 1'b0;
                    rd_flag_next = 1'b0;
                    held_next    = 16'd0;
                    state_next   = IDLE;
                end else begin
                    rd_flag_next = rd_flag_reg | addr_hit;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Zero-latency contribution to the wired-OR data bus.
    assign bus.data = (valid_reg && addr_hit) ? held_reg : 16'd0;
    assign valid    = valid_reg;

`ifdef ADC_SLOT_LOST_CNT_EN
    logic [7:0] lost_reg;
    logic       lost_inc;

    assign lost_inc = trig_edge && ((state_reg == CONV) || (state_reg == HOLD));

    always_ff @(posedge clk) begin
        if (rst) begin
            lost_reg <= 8'd0;
        end else if (lost_inc && (lost_reg != 8'hFF)) begin
            lost_reg <= lost_reg + 8'd1;
        end
    end

    assign lost = lost_reg;
`else
    assign lost = 8'd0;
`endif

endmodule

// File: tb/tb_adc_slot_responder.sv
// Directed plus randomized checks of adc_slot_responder against a cycle-level
// behavioural model of the capture/hold/release rules.
module tb_adc_slot_responder;

    localparam int          CONV = 4;
    localparam logic [15:0] TH   = 16'd100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  slot = 8'd0;
    logic        trig = 1'b0;
    logic [15:0] adc_in = 16'd0;
    logic        valid;
    logic [7:0]  lost;

    adc_slot_responder_if bus ();

    adc_slot_responder #(.CONV_CYCLES(CONV), .THRESH(TH)) dut (
        .clk    (clk),
        .rst    (rst),
        .slot   (slot),
        .bus    (bus.slave),
        .trig   (trig),
        .adc_in (adc_in),
        .valid  (valid),
        .lost   (lost)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model: conversion countdown, held hit, read-this-scan flag.
    int          m_conv = -1;
    logic        m_valid = 1'b0;
    logic [15:0] m_held = 16'd0;
    logic        m_read = 1'b0;
    int          m_lost = 0;
    logic        m_trig_d = 1'b0;

    function automatic logic [15:0] m_data();
        return (m_valid && bus.addr == slot) ? m_held : 16'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        logic e;
        logic hit;
        e = trig & ~m_trig_d;
        if (rst) begin
            m_conv = -1; m_valid = 1'b0; m_held = 16'd0;
            m_read = 1'b0; m_lost = 0; m_trig_d = 1'b0;
        end else begin
`ifdef ADC_SLOT_LOST_CNT_EN
            if (e && (m_conv >= 0 || m_valid) && m_lost < 255) m_lost++;
`endif
            if (m_conv > 0) begin
                m_conv--;
            end else if (m_conv == 0) begin
                m_conv = -1;
                if (adc_in >= TH) begin
                    m_valid = 1'b1; m_held = adc_in; m_read = 1'b0;
                end
            end else if (m_valid) begin
                hit = m_read || (bus.addr == slot);
                if (bus.clr && hit) begin
                    m_valid = 1'b0; m_held = 16'd0; m_read = 1'b0;
                end else begin
                    m_read = hit;
                end
            end else if (e) begin
                m_conv = CONV - 1;
            end
            m_trig_d = trig;
        end
    endtask

    // One clock: drive inputs on the falling edge, check data combinationally,
    // then check registered outputs just after the rising edge.
    task automatic step(input logic t, input logic [7:0] a, input logic [15:0] d,
                        input logic c, input logic r);
        @(negedge clk);
        trig = t; bus.addr = a; adc_in = d; bus.clr = c; rst = r;
        #1 check("data_comb", 32'(bus.data), 32'(m_data()));
        @(posedge clk);
        model_update();
        #1;
        check("valid", 32'(valid), 32'(m_valid));
        check("lost", 32'(lost), 32'(m_lost));
        check("data", 32'(bus.data), 32'(m_data()));
    endtask

    logic [7:0] exp_lost3;

    initial begin
        bus.addr = 8'd0;
        bus.clr  = 1'b0;
`ifdef ADC_SLOT_LOST_CNT_EN
        exp_lost3 = 8'd3;
`else
        exp_lost3 = 8'd0;
`endif
        // Reset
        step(0, 8'd0, 16'd0, 0, 1);
        step(0, 8'd0, 16'd0, 0, 1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        step(0, 8'd0, 16'd0, 0, 0);

        // Basic capture at slot 3
        slot = 8'd3;
        step(1, 8'd2, 16'd500, 0, 0);
        for (int i = 0; i < CONV - 1; i++) begin
            step(0, 8'd2, 16'd500, 0, 0);
            check("cap_early", 32'(valid), 32'd0);
        end
        step(0, 8'd2, 16'd500, 0, 0);
        check("cap_latency", 32'(valid), 32'd1);
        check("cap_other_addr", 32'(bus.data), 32'd0);
        step(0, 8'd3, 16'd0, 0, 0);
        check("cap_data", 32'(bus.data), 32'd500);
        step(0, 8'd2, 16'd0, 1, 0);
        check("cap_release", 32'(valid), 32'd0);

        // Threshold: below, then exactly at threshold
        step(1, 8'd3, 16'd50, 0, 0);
        for (int i = 0; i < CONV + 2; i++) step(0, 8'd3, 16'd50, 0, 0);
        check("thr_below", 32'(valid), 32'd0);
        step(1, 8'd3, 16'd100, 0, 0);
        for (int i = 0; i < CONV; i++) step(0, 8'd3, 16'd100, 0, 0);
        check("thr_equal_valid", 32'(valid), 32'd1);
        check("thr_equal_data", 32'(bus.data), 32'd100);
        step(0, 8'd3, 16'd0, 1, 0);

        // Unread clear keeps the hit
        slot = 8'd1;
        step(1, 8'd0, 16'd2000, 0, 0);
        for (int i = 0; i < CONV; i++) step(0, 8'd0, 16'd2000, 0, 0);
        for (int a = 2; a < 256; a++) step(0, 8'(a), 16'd0, 0, 0);
        step(0, 8'd0, 16'd0, 1, 0);
        check("unread_keep", 32'(valid), 32'd1);
        step(0, 8'd1, 16'd0, 0, 0);
        check("unread_data", 32'(bus.data), 32'd2000);
        step(0, 8'd0, 16'd0, 1, 0);
        check("read_release", 32'(valid), 32'd0);
        step(0, 8'd1, 16'd0, 0, 0);
        check("read_release_data", 32'(bus.data), 32'd0);

        // Lost triggers: one in CONV, two in HOLD
        rst = 1'b0;
        step(0, 8'd0, 16'd0, 0, 1);
        slot = 8'd5;
        step(1, 8'd0, 16'd200, 0, 0);
        step(0, 8'd0, 16'd200, 0, 0);
        step(1, 8'd0, 16'd200, 0, 0);
        step(0, 8'd0, 16'd200, 0, 0);
        step(0, 8'd0, 16'd200, 0, 0);
        check("lost_hold_entry", 32'(valid), 32'd1);
        step(1, 8'd0, 16'd0, 0, 0);
        step(0, 8'd0, 16'd0, 0, 0);
        step(1, 8'd0, 16'd0, 0, 0);
        step(0, 8'd0, 16'd0, 0, 0);
        check("lost_three", 32'(lost), 32'(exp_lost3));

        // Collision: read, then clr with trig edge on the same clock
        step(0, 8'd5, 16'd0, 0, 0);
        step(1, 8'd0, 16'd300, 1, 0);
        check("coll_valid", 32'(valid), 32'd0);
        for (int i = 0; i < CONV + 2; i++) step(1, 8'd5, 16'd300, 0, 0);
        check("coll_no_conv", 32'(valid), 32'd0);

        // Saturation
        for (int i = 0; i < 300; i++) begin
            step(1, 8'd0, 16'd200, 0, 0);
            step(0, 8'd0, 16'd200, 0, 0);
        end

        // Reset mid-CONV at cnt==1
        step(0, 8'd0, 16'd0, 0, 1);
        step(0, 8'd0, 16'd0, 0, 0);
        step(1, 8'd5, 16'd400, 0, 0);
        step(0, 8'd5, 16'd400, 0, 0);
        step(0, 8'd5, 16'd400, 0, 0);
        step(0, 8'd5, 16'd400, 0, 1);
        check("rst_conv_valid", 32'(valid), 32'd0);
        check("rst_conv_lost", 32'(lost), 32'd0);
        step(1, 8'd5, 16'd400, 0, 0);
        for (int i = 0; i < CONV; i++) step(0, 8'd5, 16'd400, 0, 0);
        check("rst_conv_recover", 32'(bus.data), 32'd400);
        // Reset mid-HOLD
        step(0, 8'd5, 16'd0, 0, 1);
        check("rst_hold_valid", 32'(valid), 32'd0);
        check("rst_hold_data", 32'(bus.data), 32'd0);
        step(1, 8'd5, 16'd150, 0, 0);
        for (int i = 0; i < CONV; i++) step(0, 8'd5, 16'd150, 0, 0);
        check("rst_hold_recover", 32'(bus.data), 32'd150);

        // Randomized traffic
        slot = 8'($urandom_range(0, 255));
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] a;
            a = ($urandom_range(0, 9) < 3) ? slot : 8'($urandom_range(0, 255));
            step(logic'($urandom_range(0, 9) < 3), a, 16'($urandom_range(0, 300)),
                 logic'($urandom_range(0, 9) < 2), logic'($urandom_range(0, 199) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
